// File: rtl/display_pkg.sv
// =============================================================================
//  Module      : display_pkg
//  Description : Shared state encoding, default frame geometry and the
//                RGB565 -> RGB888 expansion used by the display read path.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package display_pkg;

   localparam int c_def_hpixel = 640;
   localparam int c_def_vpixel = 480;
   localparam int c_cnt_w      = 19;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_STREAM  = 2'd2
   } state_t;

   // Low channel bits are refilled from the MSBs so full-scale maps to 0xFF.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
      return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rgb565_expand.sv
// =============================================================================
//  Module      : rgb565_expand
//  Description : Registered RGB565 -> RGB888 stage with valid; substitutes
//                in_alt when in_pass is low. Also used by the preview path.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rgb565_expand
   import display_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_pass,
   input  logic [15:0] in_data,
   input  logic [23:0] in_alt,
   output logic [23:0] out_data,
   output logic        out_valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= 24'h000000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            out_data <= in_pass ? rgb565_to_888(in_data) : in_alt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rgb565_display_reader.sv
// =============================================================================
//  Module      : rgb565_display_reader
//  Description : Streams RGB565 words from the SDRAM read FIFO to the HDMI
//                path as RGB888, one pixel per request, re-aligning the
//                stream between frames after underflow or short frames.
//                Optional split divider enabled by macro SPLIT_BORDER_EN.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rgb565_display_reader
   import display_pkg::*;
#(
   parameter int          HDMI_HPIXEL  = c_def_hpixel,
   parameter int          HDMI_VPIXEL  = c_def_vpixel,
   parameter int          PREFILL      = 320,
   parameter int          USEDW_W      = 10,
   parameter logic [23:0] FILL_COLOR   = 24'h000000,
   parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               pixel_req,
   input  logic               split_en,
   output logic               fifo_rd_en,
   input  logic [15:0]        fifo_rd_data,
   input  logic               fifo_empty,
   input  logic [USEDW_W-1:0] fifo_rdusedw,
   output logic [23:0]        pixel_data,
   output logic               pixel_valid,
   output logic               underflow
);

   localparam int                 c_total    = HDMI_HPIXEL * HDMI_VPIXEL;
   localparam logic [c_cnt_w-1:0] c_total_v  = c_cnt_w'(c_total);
   localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(c_total - 1);
   localparam logic [c_cnt_w-1:0] c_last_col = c_cnt_w'(HDMI_HPIXEL - 1);

   state_t               r_state, w_next;
   logic [c_cnt_w-1:0]   r_pix_cnt, r_col_cnt, r_owed;
   logic [c_cnt_w-1:0]   w_owed_next, w_owed_add;
   logic [c_cnt_w:0]     w_owed_sum;
   logic                 w_rd_en, w_drain, w_border, w_prefill_ok;
   logic                 r_underflow, r_req_d1, r_real_d1, r_border_d1;

   assign w_prefill_ok = (32'(fifo_rdusedw) >= PREFILL);

`ifdef SPLIT_BORDER_EN
   localparam logic [c_cnt_w-1:0] c_mid_l = c_cnt_w'(HDMI_HPIXEL/2 - 1);
   localparam logic [c_cnt_w-1:0] c_mid_r = c_cnt_w'(HDMI_HPIXEL/2);
   assign w_border = (r_state == ST_STREAM) && split_en &&
                     ((r_col_cnt == c_mid_l) || (r_col_cnt == c_mid_r));
`else
   logic w_unused_split;
   assign w_unused_split = split_en;
   assign w_border       = 1'b0;
`endif

   always_comb begin
      w_next      = r_state;
      w_rd_en     = 1'b0;
      w_drain     = 1'b0;
      w_owed_add  = '0;
      w_owed_sum  = '0;
      w_owed_next = r_owed;
      case (r_state)
         ST_IDLE: begin
            w_drain = (r_owed != '0) && !fifo_empty;
            if (frame_start)
               w_next = ST_PREFILL;
         end
         ST_PREFILL: begin
            // Discards left over from the previous frame must finish first.
            w_drain = (r_owed != '0) && !fifo_empty;
            if (!frame_start && w_prefill_ok && (r_owed == '0))
               w_next = ST_STREAM;
         end
         ST_STREAM: begin
            w_rd_en = pixel_req && !fifo_empty;
            if (frame_start) begin
               w_next     = ST_IDLE;
               w_owed_add = c_total_v - r_pix_cnt - {{(c_cnt_w-1){1'b0}}, w_rd_en};
            end else begin
               if (pixel_req && fifo_empty)
                  w_owed_add = c_cnt_w'(1);
               if (pixel_req && (r_pix_cnt == c_last_pix))
                  w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase

      if (w_drain)
         w_rd_en = 1'b1;

      w_owed_sum = {1'b0, r_owed} + {1'b0, w_owed_add};
      if (w_drain)
         w_owed_next = r_owed - c_cnt_w'(1);
      else if (w_owed_sum[c_cnt_w])
         w_owed_next = '1;
      else
         w_owed_next = w_owed_sum[c_cnt_w-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pix_cnt   <= '0;
         r_col_cnt   <= '0;
         r_owed      <= '0;
         r_underflow <= 1'b0;
         r_req_d1    <= 1'b0;
         r_real_d1   <= 1'b0;
         r_border_d1 <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_owed      <= w_owed_next;
         r_req_d1    <= pixel_req;
         r_real_d1   <= w_rd_en && (r_state == ST_STREAM);
         r_border_d1 <= w_border;
         case (r_state)
            ST_STREAM: begin
               if (pixel_req) begin
                  r_pix_cnt <= r_pix_cnt + c_cnt_w'(1);
                  r_col_cnt <= (r_col_cnt == c_last_col) ? '0 : r_col_cnt + c_cnt_w'(1);
                  if (fifo_empty)
                     r_underflow <= 1'b1;
               end
            end
            default: begin
               r_pix_cnt <= '0;
               r_col_cnt <= '0;
               if (frame_start)
                  r_underflow <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en = w_rd_en && !rst;
   assign underflow  = r_underflow;

   rgb565_expand u_expand (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (r_req_d1),
      .in_pass   (r_real_d1 && !r_border_d1),
      .in_data   (fifo_rd_data),
      .in_alt    (r_border_d1 ? BORDER_COLOR : FILL_COLOR),
      .out_data  (pixel_data),
      .out_valid (pixel_valid)
   );

endmodule

`default_nettype wire
